// File: rtl/mips_dmem_responder.sv
// Word-addressed data-memory target for the MEM-stage load/store path.
// Single outstanding valid/ready transaction with programmable wait states before the response.
module mips_dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_we
);

  // state  | meaning
  // S_IDLE | ready for a request
  // S_WAIT | counting wait states for the captured request
  // S_RESP | response presented, held until rsp_ready
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_we_q, rsp_we_d;

  logic [31:0]         mem [0:DEPTH-1];

  logic                req_err;
  logic                commit;
  logic                c_we, c_err;
  logic [ADDR_W-1:0]   c_addr;
  logic [31:0]         c_wdata;

  // Full 32-bit compare so out-of-range addresses never alias into mem[].
  assign req_err = (req_addr >= 32'(DEPTH));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;
    rsp_we_d  = rsp_we_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    commit    = 1'b0;
    c_we      = we_q;
    c_err     = err_q;
    c_addr    = addr_q;
    c_wdata   = wdata_q;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          err_d   = req_err;
          addr_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            // No wait states: commit straight from the request bus.
            commit  = 1'b1;
            c_we    = req_we;
            c_err   = req_err;
            c_addr  = req_addr[ADDR_W-1:0];
            c_wdata = req_wdata;
            state_d = S_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      rsp_we_d  = c_we;
      rsp_err_d = c_err;
      rdata_d   = (!c_we && !c_err) ? mem[c_addr] : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      rsp_err_q <= 1'b0;
      rsp_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
      rsp_we_q  <= rsp_we_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && commit && c_we && !c_err) mem[c_addr] <= c_wdata;
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_we    = rsp_we_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: three builds (1, 0 and 3 wait states) driven one at a time,
// with a reference memory model feeding a scoreboard of expected responses.
module tb_mips_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, rsp_we;
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [31:0] rsp_rdata [3];

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [3][1024];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_dmem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .rsp_we(rsp_we[0]));

  mips_dmem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .rsp_we(rsp_we[1]));

  mips_dmem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]), .rsp_we(rsp_we[2]));

  function automatic int wc(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // One transaction on instance d; hold = cycles of response backpressure.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold, output int acc);
    exp_t e;
    int   n;
    int   lat;
    e.we    = we;
    e.err   = (addr >= 32'd1024);
    e.rdata = 32'd0;
    if (!e.err) begin
      if (we) mdl[d][addr[9:0]] = wdata;
      else    e.rdata = mdl[d][addr[9:0]];
    end
    sb.push_back(e);
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_valid[d] = 1'b1;
    rsp_ready[d] = (hold == 0);
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (n >= 50) begin n_err++; $display("FAIL accept_timeout dut%0d: no req_ready in %0d cycles", d, n); end
    acc = cyc + 1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (n >= 50) begin n_err++; $display("FAIL rsp_timeout dut%0d: no rsp_valid in %0d cycles", d, n); end
    lat = cyc + 1 - acc;
    n_cmp++;
    if (lat != wc(d) + 1) begin
      n_err++; $display("FAIL latency dut%0d addr=%0h: got %0d required %0d", d, addr, lat, wc(d) + 1);
    end
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      n_cmp++;
      if (rsp_valid[d] !== 1'b1 || req_ready[d] !== 1'b0 || rsp_rdata[d] !== e.rdata ||
          rsp_err[d] !== e.err || rsp_we[d] !== e.we) begin
        n_err++;
        $display("FAIL hold_stable dut%0d cyc%0d: valid=%b ready=%b rdata=%0h err=%b we=%b required 1 0 %0h %b %b",
                 d, h, rsp_valid[d], req_ready[d], rsp_rdata[d], rsp_err[d], rsp_we[d], e.rdata, e.err, e.we);
      end
      @(posedge clk); #1;
    end
    rsp_ready[d] = 1'b1;
    n_cmp++;
    if (rsp_rdata[d] !== e.rdata) begin n_err++; $display("FAIL rdata dut%0d addr=%0h: got %0h required %0h", d, addr, rsp_rdata[d], e.rdata); end
    n_cmp++;
    if (rsp_err[d] !== e.err) begin n_err++; $display("FAIL err dut%0d addr=%0h: got %b required %b", d, addr, rsp_err[d], e.err); end
    n_cmp++;
    if (rsp_we[d] !== e.we) begin n_err++; $display("FAIL we dut%0d addr=%0h: got %b required %b", d, addr, rsp_we[d], e.we); end
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      n_err++; $display("FAIL back_to_idle dut%0d: valid=%b ready=%b required 0 1", d, rsp_valid[d], req_ready[d]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'd0 ||
          rsp_err[d] !== 1'b0 || rsp_we[d] !== 1'b0) begin
        n_err++;
        $display("FAIL %s dut%0d: ready=%b valid=%b rdata=%0h err=%b we=%b required 1 0 0 0 0",
                 tag, d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d], rsp_we[d]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read;
    int acc;
    txn(0, 1'b0, 32'd120, 32'd0, 0, acc);
  endtask

  task automatic test_write_then_read;
    int acc;
    txn(0, 1'b1, 32'd121, 32'd130, 0, acc);
    txn(0, 1'b0, 32'd121, 32'd0, 0, acc);
    n_cmp++;
    if (u_dut1.mem[120] !== 32'd85) begin n_err++; $display("FAIL mem120_kept: got %0h required 55", u_dut1.mem[120]); end
  endtask

  task automatic test_range_err;
    int acc;
    txn(0, 1'b0, 32'd1024, 32'd0, 0, acc);
    txn(0, 1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, acc);
    txn(0, 1'b1, 32'd1024, 32'hCAFE_F00D, 0, acc);
    n_cmp++;
    if (u_dut1.mem[0] !== mdl[0][0]) begin n_err++; $display("FAIL mem0_kept: got %0h required %0h", u_dut1.mem[0], mdl[0][0]); end
    n_cmp++;
    if (u_dut1.mem[1023] !== mdl[0][1023]) begin n_err++; $display("FAIL mem1023_kept: got %0h required %0h", u_dut1.mem[1023], mdl[0][1023]); end
  endtask

  task automatic test_backpressure;
    int acc;
    txn(0, 1'b0, 32'd120, 32'd0, 5, acc);
  endtask

  task automatic test_back_to_back;
    int acc;
    int prev;
    for (int d = 1; d < 3; d++) begin
      for (int k = 0; k < 4; k++) begin
        txn(d, 1'b0, 32'd10 + 32'(k), 32'd0, 0, acc);
        if (k > 0) begin
          n_cmp++;
          if (acc - prev != wc(d) + 2) begin
            n_err++; $display("FAIL accept_spacing dut%0d k=%0d: got %0d required %0d", d, k, acc - prev, wc(d) + 2);
          end
        end
        prev = acc;
      end
    end
  endtask

  task automatic test_reset_in_wait;
    int acc;
    int n;
    req_we[0] = 1'b1; req_addr[0] = 32'd5; req_wdata[0] = 32'd7; req_valid[0] = 1'b1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset_in_wait");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid[0] !== 1'b0) begin n_err++; $display("FAIL aborted_rsp cyc%0d: got %b required 0", k, rsp_valid[0]); end
    end
    n_cmp++;
    if (u_dut1.mem[5] !== 32'd0) begin n_err++; $display("FAIL aborted_write: mem[5] got %0h required 0", u_dut1.mem[5]); end
    txn(0, 1'b0, 32'd5, 32'd0, 0, acc);
  endtask

  task automatic test_reset_in_resp;
    int acc;
    int n;
    rsp_ready[0] = 1'b0;
    req_we[0] = 1'b1; req_addr[0] = 32'd200; req_wdata[0] = 32'd55; req_valid[0] = 1'b1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (n >= 50) begin n_err++; $display("FAIL resp_reset_timeout: no rsp_valid in %0d cycles", n); end
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset_in_resp");
    rst_n = 1'b1;
    rsp_ready[0] = 1'b1;
    mdl[0][200] = 32'd55;
    n_cmp++;
    if (u_dut1.mem[200] !== 32'd55) begin n_err++; $display("FAIL committed_write: mem[200] got %0h required 37", u_dut1.mem[200]); end
    @(posedge clk); #1;
    txn(0, 1'b0, 32'd200, 32'd0, 0, acc);
  endtask

  initial begin
    req_valid = '0; req_we = '0; rsp_ready = '1;
    for (int d = 0; d < 3; d++) begin req_addr[d] = 32'd0; req_wdata[d] = 32'd0; end
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      u_dut1.mem[i] = 32'h5A00_0000 + 32'(i * 3);
      mdl[0][i]     = 32'h5A00_0000 + 32'(i * 3);
    end
    u_dut1.mem[120] = 32'd85;  mdl[0][120] = 32'd85;
    u_dut1.mem[5]   = 32'd0;   mdl[0][5]   = 32'd0;
    for (int k = 10; k < 14; k++) begin
      u_dut0.mem[k] = 32'h1000 + 32'(k); mdl[1][k] = 32'h1000 + 32'(k);
      u_dut3.mem[k] = 32'h3000 + 32'(k); mdl[2][k] = 32'h3000 + 32'(k);
    end
    test_reset();
    test_read();
    test_write_then_read();
    test_range_err();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wait();
    test_reset_in_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
